// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared types and constants for the data-memory responder.
//   - mem_resp_state_t : controller states
//   - TEST_READY_WORD  : word returned on a test read once the memory is ready
// ----------------------------------------------------------------------------
package mem_responder_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,  // power-up wait, functional port ignored
    IDLE    = 2'd1,  // accepting functional requests
    RD_WAIT = 2'd2,  // read in flight, counting latency
    RESP    = 2'd3   // read data presented for one cycle
  } mem_resp_state_t;

  localparam logic [31:0] TEST_READY_WORD = 32'hFFFF_FFFF;

endpackage : mem_responder_pkg

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//   Load/store chip-select bus between the core (master) and the data-memory
//   responder (slave), including the startup test port.
//   Functional: csb, web, addr, wdata -> ; <- rdata, rdata_valid, busy
//   Test:       test_en, test_mem_en, test_mem_we -> ; <- test_rdata, ready
// ----------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              csb;
  logic              web;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              busy;
  logic              test_en;
  logic              test_mem_en;
  logic              test_mem_we;
  logic [DATA_W-1:0] test_rdata;
  logic              ready;

  modport master (
    output csb, web, addr, wdata, test_en, test_mem_en, test_mem_we,
    input  rdata, rdata_valid, busy, test_rdata, ready
  );

  modport slave (
    input  csb, web, addr, wdata, test_en, test_mem_en, test_mem_we,
    output rdata, rdata_valid, busy, test_rdata, ready
  );

endinterface : mem_responder_if

// File: rtl/mem_responder_array.sv
// ----------------------------------------------------------------------------
// mem_resp_array
//   Single-port-per-direction word storage: synchronous write, registered read.
//   clk   : clock, rising edge
//   we    : write enable, writes wdata to mem[waddr] on the edge
//   waddr : write word address
//   wdata : write data
//   re    : read enable, loads rdata from mem[raddr] on the edge
//   raddr : read word address
//   rdata : registered read data (holds between reads)
// ----------------------------------------------------------------------------
module mem_resp_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: storage and its read register have no reset so they map onto RAM
  // macros; the top gates rdata so nothing undefined reaches the bus.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata      <= mem[raddr];
  end

endmodule : mem_resp_array

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Data-memory responder on the memory side of the core's chip-select bus.
//   Writes complete on the accepting edge; reads return after RD_LAT cycles
//   with a one-cycle rdata_valid pulse, busy covering the whole read window.
//   A startup test port lets the core write once and then poll until the
//   memory answers TEST_READY_WORD.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : mem_responder_if.slave (functional + test port)
// ----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 3,   // 1..15
  parameter int INIT_CYCLES = 13   // 1..255
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [3:0] LAT_LAST  = 4'(RD_LAT - 1);

  mem_resp_state_t   state;
  mem_resp_state_t   next_state;
  logic [7:0]        init_cnt;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              test_wr_seen;
  logic [DATA_W-1:0] test_rdata_q;

  logic              wr_req;
  logic              rd_req;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] array_q;
  logic              busy;
  logic              rdata_valid;
  logic              ready;

  // Functional requests only count when the test port has released the bus.
  assign wr_req = !bus.test_en && !bus.csb && !bus.web;
  assign rd_req = !bus.test_en && !bus.csb &&  bus.web;

  // ---------------- state register ----------------
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // ---------------- next-state logic ----------------
  // NOTE: next_state takes its default before the case so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (init_cnt == INIT_LAST) next_state = IDLE;
      IDLE:    if (rd_req) next_state = (RD_LAT == 1) ? RESP : RD_WAIT;
      RD_WAIT: if (lat_cnt == LAT_LAST) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    mem_we      = (state == IDLE) && wr_req;
    // Load the array's read register on the edge that enters RESP so the
    // word is on its output for exactly the RESP cycle.
    mem_re      = (next_state == RESP);
    // The latched address is not yet available on the accepting edge, which
    // matters when RD_LAT = 1.
    mem_raddr   = (state == IDLE) ? bus.addr : addr_q;
    busy        = (state == RD_WAIT) || (state == RESP);
    rdata_valid = (state == RESP);
  end

  // ---------------- counters and read address latch ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
      lat_cnt  <= '0;
      addr_q   <= '0;
    end else begin
      if (state == INIT) init_cnt <= init_cnt + 8'd1;
      if (state == IDLE && rd_req) begin
        lat_cnt <= 4'd1;
        addr_q  <= bus.addr;
      end else if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
    end
  end

  // ---------------- startup test port ----------------
  assign ready = (state != INIT) && test_wr_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_wr_seen <= 1'b0;
      test_rdata_q <= '0;
    end else if (bus.test_en && bus.test_mem_en) begin
      if (bus.test_mem_we) test_wr_seen <= 1'b1;
      else                 test_rdata_q <= ready ? DATA_W'(TEST_READY_WORD) : '0;
    end
  end

  // ---------------- storage ----------------
  mem_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.addr),
    .wdata (bus.wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (array_q)
  );

  assign bus.rdata       = rdata_valid ? array_q : '0;
  assign bus.rdata_valid = rdata_valid;
  assign bus.busy        = busy;
  assign bus.test_rdata  = test_rdata_q;
  assign bus.ready       = ready;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//   Drives identical stimulus into two responders (RD_LAT = 3 and RD_LAT = 1)
//   and compares every output each cycle against a timeline model: a request
//   accepted in cycle k makes the responder busy for cycles k+1..k+RD_LAT
//   and answers in cycle k+RD_LAT.
// ----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int INIT_CYCLES = 13;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();
  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .INIT_CYCLES(INIT_CYCLES)
  ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .INIT_CYCLES(INIT_CYCLES)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          k;                 // cycles since reset release
  bit          seen;              // a test write has been issued
  logic [31:0] exp_trd;
  int          acc [2];           // cycle the last read was accepted
  int          resp [2];          // cycle its answer is due
  logic [31:0] rdat [2];
  bit          rknown [2];
  logic [31:0] mem_m [2][256];
  bit          known [2][256];

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic bit m_ready();
    return (k >= INIT_CYCLES) && seen;
  endfunction

  // ---------------- observation ----------------
  logic [31:0] o_rdata [2];
  logic [31:0] o_trd   [2];
  logic        o_rv    [2];
  logic        o_busy  [2];
  logic        o_rdy   [2];

  task automatic sample();
    o_rdata[0] = bus3.rdata;  o_rdata[1] = bus1.rdata;
    o_trd[0]   = bus3.test_rdata; o_trd[1] = bus1.test_rdata;
    o_rv[0]    = bus3.rdata_valid; o_rv[1] = bus1.rdata_valid;
    o_busy[0]  = bus3.busy;   o_busy[1]  = bus1.busy;
    o_rdy[0]   = bus3.ready;  o_rdy[1]   = bus1.ready;
  endtask

  task automatic check_cycle();
    bit b;
    sample();
    for (int d = 0; d < 2; d++) begin
      b = (k > acc[d]) && (k <= resp[d]);
      check($sformatf("lat%0d c%0d ready", lat_of(d), k), 32'(o_rdy[d]), 32'(m_ready()));
      check($sformatf("lat%0d c%0d busy", lat_of(d), k), 32'(o_busy[d]), 32'(b));
      check($sformatf("lat%0d c%0d rdata_valid", lat_of(d), k), 32'(o_rv[d]), 32'(k == resp[d]));
      check($sformatf("lat%0d c%0d test_rdata", lat_of(d), k), o_trd[d], exp_trd);
      if (k == resp[d] && rknown[d])
        check($sformatf("lat%0d c%0d rdata", lat_of(d), k), o_rdata[d], rdat[d]);
    end
  endtask

  task automatic drive(input bit te, input bit tme, input bit tmw, input bit cs,
                       input bit we_b, input logic [7:0] a, input logic [31:0] wd);
    bus3.test_en = te; bus3.test_mem_en = tme; bus3.test_mem_we = tmw;
    bus3.csb = cs; bus3.web = we_b; bus3.addr = a; bus3.wdata = wd;
    bus1.test_en = te; bus1.test_mem_en = tme; bus1.test_mem_we = tmw;
    bus1.csb = cs; bus1.web = we_b; bus1.addr = a; bus1.wdata = wd;
  endtask

  // One clock cycle: check current outputs, apply inputs, advance the model.
  task automatic step(input bit te, input bit tme, input bit tmw, input bit cs,
                      input bit we_b, input logic [7:0] a, input logic [31:0] wd);
    bit rdy;
    check_cycle();
    drive(te, tme, tmw, cs, we_b, a, wd);
    rdy = m_ready();
    if (te && tme) begin
      if (tmw) seen = 1'b1;
      else     exp_trd = rdy ? 32'hFFFF_FFFF : 32'h0;
    end
    for (int d = 0; d < 2; d++) begin
      if (!te && !cs && k >= INIT_CYCLES && k > resp[d]) begin
        if (!we_b) begin
          mem_m[d][a] = wd;
          known[d][a] = 1'b1;
        end else begin
          acc[d]    = k;
          resp[d]   = k + lat_of(d);
          rdat[d]   = mem_m[d][a];
          rknown[d] = known[d][a];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 32'd0);
  endtask

  // Assert reset (outputs must clear at once), hold across an edge, release.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    sample();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("lat%0d rst rdata", lat_of(d)), o_rdata[d], 32'h0);
      check($sformatf("lat%0d rst rdata_valid", lat_of(d)), 32'(o_rv[d]), 32'h0);
      check($sformatf("lat%0d rst busy", lat_of(d)), 32'(o_busy[d]), 32'h0);
      check($sformatf("lat%0d rst test_rdata", lat_of(d)), o_trd[d], 32'h0);
      check($sformatf("lat%0d rst ready", lat_of(d)), 32'(o_rdy[d]), 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    k       = 0;
    seen    = 1'b0;
    exp_trd = 32'h0;
    for (int d = 0; d < 2; d++) begin
      acc[d]  = -1;
      resp[d] = -1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 32'd0);

    // No test write: polling must never see ready.
    do_reset();
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), $urandom);

    // Test write at cycle 2, then poll: ready at cycle 13, all-ones from 14.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, (i == 2), 1'b1, 1'b1, 8'd0, 32'd0);

    // Write, read-after-write, ignored write while busy, re-read.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 32'h0000_0001);
    for (int i = 0; i < 4; i++) idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 32'd0);
    for (int i = 0; i < 5; i++) idle();

    // Fill low addresses with known data, then random traffic.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i), $urandom);
      for (int j = 0; j < 4; j++) idle();
    end
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
    for (int i = 0; i < 5; i++) idle();

    // Back-to-back reads every cycle.
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 15)), 32'd0);
    for (int i = 0; i < 5; i++) idle();

    // Reset while the RD_LAT=3 responder is in RD_WAIT.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 32'd0);
    check_cycle();
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, (i == 1), 1'b0, 1'b1, 8'd3, 32'd0);
    for (int i = 0; i < 4; i++) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_responder
